// File: rtl/cordic_request_arbiter_if.sv
// Request/response/core bundle for the shared CORDIC arbiter.
// master = arbiter side, slave = requesters, consumer and core side.
interface cordic_request_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*4-1:0]     req_op;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ*WIDTH-1:0] req_y;
    logic [NUM_REQ*WIDTH-1:0] req_z;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;

    logic             core_enable;
    logic [3:0]       core_op;
    logic [WIDTH-1:0] core_x;
    logic [WIDTH-1:0] core_y;
    logic [WIDTH-1:0] core_z;
    logic [WIDTH-1:0] core_result;
    logic             core_done;

    modport master (
        input  req_valid, req_op, req_x, req_y, req_z,
        output req_ready,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_err,
        output core_enable, core_op, core_x, core_y, core_z,
        input  core_result, core_done
    );

    modport slave (
        output req_valid, req_op, req_x, req_y, req_z,
        input  req_ready,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_err,
        input  core_enable, core_op, core_x, core_y, core_z,
        output core_result, core_done
    );
endinterface

// File: rtl/cordic_request_arbiter.sv
// Round-robin arbiter sharing one CORDIC core among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining CORDIC_ARB_WATCHDOG_EN.
module cordic_request_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 32,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    cordic_request_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    win_id;
    logic               win_found;
    logic [NUM_REQ-1:0] grant;
    logic               hs;
    logic               first_q, first_d;
    logic               done_ok;
    logic               timeout;

    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             rv_q, rv_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;

    function automatic logic [ID_W-1:0] rr_idx(
        input logic [ID_W-1:0] base,
        input int              k
    );
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[ID_W-1:0];
    endfunction

    // Reverse scan so the closest valid requester after ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[rr_idx(ptr_q, k)]) begin
                win_found = 1'b1;
                win_id    = rr_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (win_found && rst_n) grant[win_id] = 1'b1;
    end

    assign hs      = (state_q == IDLE) && win_found;
    assign done_ok = (state_q == WAIT) && !first_q && bus.core_done;

`ifdef CORDIC_ARB_WATCHDOG_EN
    logic [15:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (state_q == ISSUE)     wd_d = '0;
        else if (state_q == WAIT) wd_d = wd_q + 16'd1;
    end

    assign timeout = (state_q == WAIT) && !done_ok &&
                     (wd_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_found) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done_ok || timeout) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = '0;
        bus.core_enable = 1'b0;
        unique case (state_q)
            IDLE:    bus.req_ready   = grant;
            ISSUE:   bus.core_enable = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        id_d    = id_q;
        first_d = first_q;
        rv_d    = rv_q;
        res_d   = res_q;
        err_d   = err_q;
        if (hs) begin
            ptr_d = rr_idx(win_id, 1);
            op_d  = bus.req_op[int'(win_id)*4 +: 4];
            x_d   = bus.req_x[int'(win_id)*WIDTH +: WIDTH];
            y_d   = bus.req_y[int'(win_id)*WIDTH +: WIDTH];
            z_d   = bus.req_z[int'(win_id)*WIDTH +: WIDTH];
            id_d  = win_id;
        end
        // A done left high by the previous op must not end this one.
        if (state_q == ISSUE) first_d = 1'b1;
        if (state_q == WAIT)  first_d = 1'b0;
        if (done_ok) begin
            rv_d  = 1'b1;
            res_d = bus.core_result;
            err_d = 1'b0;
        end else if (timeout) begin
            rv_d  = 1'b1;
            res_d = '0;
            err_d = 1'b1;
        end
        if (state_q == RESP && bus.rsp_ready) rv_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            id_q    <= '0;
            first_q <= 1'b0;
            rv_q    <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            id_q    <= id_d;
            first_q <= first_d;
            rv_q    <= rv_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.core_op    = op_q;
    assign bus.core_x     = x_q;
    assign bus.core_y     = y_q;
    assign bus.core_z     = z_q;
    assign bus.rsp_valid  = rv_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_cordic_request_arbiter.sv
// Randomized bench for cordic_request_arbiter with a transaction-level
// model, a behavioural core stub and literal directed expectations.
module tb_cordic_request_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cordic_request_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

    cordic_request_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .ID_W(IW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] core_fn(input logic [3:0] op,
        input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        return (x ^ z) + y + W'(op);
    endfunction

    assign bus.core_result = core_fn(bus.core_op, bus.core_x,
                                     bus.core_y, bus.core_z);

    // stimulus controls written by the main sequence
    int gen_mode  = 0; // 0 none, 1 all valid, 2 random, 3 single req0
    int rr_mode   = 0; // 0 ready high, 1 random, 2 held low
    int stub_mode = 0; // 0 random latency, 1 done stuck high, 2 never
    int s_seq     = 0;
    logic [3:0]   s_op;
    logic [W-1:0] s_x, s_y, s_z;

    // written by the compare process
    int   cyc = 0;
    logic ce_seen = 1'b0;
    int   ce_count = 0;
    int   grant_cnt [N];
    int   grant_q [$];
    int   log_id [$];
    logic [W-1:0] log_res [$];
    logic log_err [$];
    int   log_lat [$];

    // driver for requesters, response consumer and core stub
    initial begin
        int seen [N];
        int s_applied;
        int stub_cnt;
        bit stub_pend;
        s_applied = 0;
        stub_cnt  = 0;
        stub_pend = 0;
        for (int i = 0; i < N; i++) seen[i] = 0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_z     = '0;
        bus.rsp_ready = 1'b0;
        bus.core_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                bit g;
                g = (grant_cnt[i] != seen[i]);
                seen[i] = grant_cnt[i];
                if (g || !bus.req_valid[i]) begin
                    bus.req_op[i*4 +: 4] = 4'($urandom);
                    bus.req_x[i*W +: W]  = $urandom;
                    bus.req_y[i*W +: W]  = $urandom;
                    bus.req_z[i*W +: W]  = $urandom;
                end
                case (gen_mode)
                    1: bus.req_valid[i] = 1'b1;
                    2: if (g) bus.req_valid[i] = 1'($urandom_range(0, 1));
                       else if ($urandom_range(0, 7) == 0)
                           bus.req_valid[i] = ~bus.req_valid[i];
                    3: if (g || i != 0) bus.req_valid[i] = 1'b0;
                    default: bus.req_valid[i] = 1'b0;
                endcase
            end
            if (gen_mode == 3 && s_seq != s_applied) begin
                s_applied = s_seq;
                bus.req_op[3:0]  = s_op;
                bus.req_x[W-1:0] = s_x;
                bus.req_y[W-1:0] = s_y;
                bus.req_z[W-1:0] = s_z;
                bus.req_valid[0] = 1'b1;
            end
            case (rr_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
            if (ce_seen) begin
                stub_pend = 1;
                stub_cnt  = $urandom_range(0, 6);
            end else if (stub_cnt > 0) begin
                stub_cnt--;
            end
            case (stub_mode)
                1:       bus.core_done = 1'b1;
                2:       bus.core_done = 1'b0;
                default: bus.core_done = stub_pend && stub_cnt == 0;
            endcase
        end
    end

    // reference model and per-cycle compare
    bit   m_busy = 0, m_resp = 0, m_err = 0;
    int   m_ptr = 0, m_hs = 0, m_id = 0, m_lat = 0;
    logic [3:0]   m_op;
    logic [W-1:0] m_x, m_y, m_z, m_res;

    always @(negedge clk) begin
        int win;
        logic [N-1:0] exp_rdy;
        cyc++;
        ce_seen = bus.core_enable;
        if (!rst_n) begin
            m_busy = 0;
            m_resp = 0;
            m_ptr  = 0;
            chk("reset_outputs",
                {bus.req_ready, bus.rsp_valid, bus.core_enable}, '0);
        end else begin
            if (bus.core_enable) ce_count++;
            win = -1;
            exp_rdy = '0;
            if (!m_busy) begin
                for (int k = N - 1; k >= 0; k--)
                    if (bus.req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                if (win >= 0) exp_rdy[win] = 1'b1;
            end
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("core_enable", bus.core_enable,
                64'(m_busy && !m_resp && cyc == m_hs + 1));
            if (m_busy && cyc > m_hs) begin
                chk("core_op", bus.core_op, m_op);
                chk("core_x", bus.core_x, m_x);
                chk("core_y", bus.core_y, m_y);
                chk("core_z", bus.core_z, m_z);
            end
            if (m_resp) begin
                chk("rsp_valid", bus.rsp_valid, 1);
                chk("rsp_id", bus.rsp_id, 64'(m_id));
                chk("rsp_result", bus.rsp_result, m_res);
                chk("rsp_err", bus.rsp_err, m_err);
            end else begin
                chk("rsp_valid", bus.rsp_valid, 0);
            end
            if (m_resp) begin
                if (bus.rsp_ready) begin
                    m_busy = 0;
                    m_resp = 0;
                    log_id.push_back(m_id);
                    log_res.push_back(m_res);
                    log_err.push_back(m_err);
                    log_lat.push_back(m_lat);
                end
            end else if (m_busy) begin
                if (cyc >= m_hs + 3 && bus.core_done) begin
                    m_resp = 1;
                    m_res  = core_fn(m_op, m_x, m_y, m_z);
                    m_err  = 0;
                    m_lat  = cyc + 1 - m_hs;
                end
`ifdef CORDIC_ARB_WATCHDOG_EN
                else if (cyc == m_hs + 1 + TO) begin
                    m_resp = 1;
                    m_res  = '0;
                    m_err  = 1;
                    m_lat  = cyc + 1 - m_hs;
                end
`endif
                else if (cyc - m_hs > 200) begin
                    chk("wait_bound", 64'(cyc - m_hs), 0);
                    m_busy = 0;
                end
            end else if (win >= 0) begin
                m_busy = 1;
                m_hs   = cyc;
                m_id   = win;
                m_op   = bus.req_op[win*4 +: 4];
                m_x    = bus.req_x[win*W +: W];
                m_y    = bus.req_y[win*W +: W];
                m_z    = bus.req_z[win*W +: W];
                m_ptr  = (win + 1) % N;
                grant_q.push_back(win);
                grant_cnt[win]++;
            end
        end
    end

    task automatic wait_rsp(input int target, input string nm);
        int k;
        k = 0;
        while (log_id.size() < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 64'(log_id.size() >= target), 1);
    endtask

    initial begin
        int n0, c0, g0, k, hid;
        logic [W-1:0] hres;
        logic [3:0] e_op;
        logic [W-1:0] e_x, e_y, e_z;

        for (int i = 0; i < N; i++) grant_cnt[i] = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_id}, '0);
        chk("rst_result", bus.rsp_result, '0);
        chk("rst_core", {bus.core_enable, bus.core_op, bus.core_x}, '0);
        chk("rst_core_yz", {bus.core_y, bus.core_z}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single ATANH-style request on requester 0
        n0 = log_id.size();
        c0 = ce_count;
        s_op = 4'd5;
        s_x = 32'h0001_0000;
        s_y = 32'h0000_8000;
        s_z = 32'h0;
        gen_mode = 3;
        s_seq++;
        wait_rsp(n0 + 1, "t1_response");
        chk("t1_id", 64'(log_id[n0]), 0);
        chk("t1_result", log_res[n0], 32'h0001_8005);
        chk("t1_err", log_err[n0], 0);
        chk("t1_enable_pulses", 64'(ce_count - c0), 1);
        chk("t1_latency_min", 64'(log_lat[n0] >= 4), 1);

        // done stuck high: captured exactly at handshake+3
        repeat (3) @(negedge clk);
        n0 = log_id.size();
        stub_mode = 1;
        e_op = 4'($urandom);
        e_x = $urandom;
        e_y = $urandom;
        e_z = $urandom;
        s_op = e_op;
        s_x = e_x;
        s_y = e_y;
        s_z = e_z;
        s_seq++;
        wait_rsp(n0 + 1, "t5_response");
        chk("t5_latency", 64'(log_lat[n0]), 4);
        chk("t5_result", log_res[n0], core_fn(e_op, e_x, e_y, e_z));
        stub_mode = 0;

        // consumer stalls for 20 cycles
        gen_mode = 1;
        rr_mode = 2;
        k = 0;
        @(negedge clk);
        while (!bus.rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t3_rsp_seen", bus.rsp_valid, 1);
        hid = int'(bus.rsp_id);
        hres = bus.rsp_result;
        repeat (20) begin
            @(negedge clk);
            chk("t3_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_result,
                            bus.req_ready},
                {1'b1, 2'(hid), hres, 4'b0000});
        end
        rr_mode = 0;
        @(negedge clk);
        chk("t3_release", {bus.rsp_valid, bus.rsp_ready}, 2'b11);
        @(negedge clk);
        chk("t3_next_grant", 64'(|bus.req_ready), 1);

        // reset in the first WAIT cycle, valids kept high
        k = 0;
        while (!bus.core_enable && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4_enable_seen", bus.core_enable, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t4_async_zero",
            {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
             bus.core_enable, bus.core_op}, '0);
        chk("t4_async_data", {bus.core_x, bus.rsp_result}, '0);
        g0 = grant_q.size();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t4_first_ready", bus.req_ready, 4'b0001);
        chk("t4_no_stale", bus.rsp_valid, 0);

        // all requesters busy: strict rotation from 0
        k = 0;
        while (grant_q.size() < g0 + 8 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("t2_grants", 64'(grant_q.size() >= g0 + 8), 1);
        for (int i = 0; i < 8; i++)
            chk("t2_order", 64'(grant_q[g0 + i]), 64'(i % 4));

        // random traffic
        n0 = log_id.size();
        gen_mode = 2;
        rr_mode = 1;
        repeat (2000) @(negedge clk);
        gen_mode = 0;
        rr_mode = 0;
        repeat (40) @(negedge clk);
        chk("rand_traffic", 64'(log_id.size() - n0 > 50), 1);

`ifdef CORDIC_ARB_WATCHDOG_EN
        // core never finishes: watchdog response
        n0 = log_id.size();
        stub_mode = 2;
        gen_mode = 3;
        s_op = 4'd2;
        s_x = $urandom;
        s_y = $urandom;
        s_z = $urandom;
        s_seq++;
        wait_rsp(n0 + 1, "t6_response");
        chk("t6_latency", 64'(log_lat[n0]), 64'(TO + 2));
        chk("t6_err", log_err[n0], 1);
        chk("t6_result", log_res[n0], 0);
        stub_mode = 0;
        repeat (5) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
